// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared constants and types for the instruction memory block.
//   NOP_INSTR          : word shown on `instruction` while no real data is held
//                        (RISC-V "addi x0, x0, 0").
//   DEFAULT_BUS_WIDTH  : default instruction word width.
//   DEFAULT_DEPTH      : default number of words (power of two, >= 2).
//   instr_t            : instruction word at the default width.
// ---------------------------------------------------------------------------
package instr_mem_pkg;

    localparam int DEFAULT_BUS_WIDTH = 32;
    localparam int DEFAULT_DEPTH     = 256;

    typedef logic [DEFAULT_BUS_WIDTH-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0013;

endpackage : instr_mem_pkg

// File: rtl/instr_mem_if.sv
// ---------------------------------------------------------------------------
// instr_mem_if
// Bundle of the fetch, program-load and (optionally) jump signals of the
// instruction memory.
//   master : the core / loader side (drives next_instr, wr_*, jmp_*).
//   slave  : the instruction memory (drives instruction, pc, instr_valid).
// Optional feature macro: INSTR_MEM_JUMP_EN adds jmp_en / jmp_addr.
// ---------------------------------------------------------------------------
interface instr_mem_if #(
    parameter int BUS_WIDTH = instr_mem_pkg::DEFAULT_BUS_WIDTH,
    parameter int DEPTH     = instr_mem_pkg::DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH)
);
    logic                 next_instr;
    logic [BUS_WIDTH-1:0] instruction;
    logic [ADDR_W-1:0]    pc;
    logic                 instr_valid;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BUS_WIDTH-1:0] wr_data;
`ifdef INSTR_MEM_JUMP_EN
    logic                 jmp_en;
    logic [ADDR_W-1:0]    jmp_addr;

    modport master (
        output next_instr, wr_en, wr_addr, wr_data, jmp_en, jmp_addr,
        input  instruction, pc, instr_valid
    );
    modport slave (
        input  next_instr, wr_en, wr_addr, wr_data, jmp_en, jmp_addr,
        output instruction, pc, instr_valid
    );
`else
    modport master (
        output next_instr, wr_en, wr_addr, wr_data,
        input  instruction, pc, instr_valid
    );
    modport slave (
        input  next_instr, wr_en, wr_addr, wr_data,
        output instruction, pc, instr_valid
    );
`endif
endinterface : instr_mem_if

// File: rtl/instr_mem_ram.sv
// ---------------------------------------------------------------------------
// instr_mem_ram
// Single-write, single-synchronous-read word array. Read-before-write: a
// read and a write of the same address on one edge returns the old word.
// The array is never reset so a loaded program survives core resets.
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write word address
//   wr_data  : write data
//   rd_addr  : read word address, sampled every edge
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module instr_mem_ram
    import instr_mem_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Both accesses in one block: the read samples mem before the
    // non-blocking write lands, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule : instr_mem_ram

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
// Instruction memory of the RISC-V core: a DEPTH x BUS_WIDTH program store
// with an internal read pointer presenting the current instruction.
//   clk              : rising-edge clock
//   rst              : asynchronous active-high reset (pointer/valid only,
//                      memory contents are kept)
//   bus.next_instr   : current instruction executed, advance pointer
//   bus.instruction  : current instruction (NOP_INSTR while not valid)
//   bus.pc           : word address of bus.instruction
//   bus.instr_valid  : bus.instruction holds real memory data
//   bus.wr_en/wr_addr/wr_data : program-load write port
//   bus.jmp_en/jmp_addr       : pointer load (only with INSTR_MEM_JUMP_EN)
// Optional feature macro: INSTR_MEM_JUMP_EN.
// DEPTH must be a power of two >= 2 so the pointer wraps by overflow.
// ---------------------------------------------------------------------------
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    instr_mem_if.slave bus
);

    localparam logic [BUS_WIDTH-1:0] NOP_WORD = BUS_WIDTH'(NOP_INSTR);

    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    pc_d;
    logic                 valid_q;
    logic [BUS_WIDTH-1:0] ram_rdata;

    // Next pointer: jump beats step, step only once real data is shown.
    // Increment overflows naturally from DEPTH-1 to 0.
    always_comb begin
        pc_d = pc_q;
`ifdef INSTR_MEM_JUMP_EN
        if (bus.jmp_en) begin
            pc_d = bus.jmp_addr;
        end else if (bus.next_instr && valid_q) begin
            pc_d = pc_q + ADDR_W'(1);
        end
`else
        if (bus.next_instr && valid_q) begin
            pc_d = pc_q + ADDR_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

    // The RAM reads mem[pc_d] on every edge, so a held pointer still picks
    // up a write to its own address one edge later.
    instr_mem_ram #(
        .WIDTH  (BUS_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (pc_d),
        .rd_data (ram_rdata)
    );

    // The RAM output register has no reset; masking it with the reset-able
    // valid flag makes the NOP appear immediately when rst is asserted.
    assign bus.instruction = valid_q ? ram_rdata : NOP_WORD;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = valid_q;

endmodule : instr_mem

// File: tb/tb_instr_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_mem
// Directed steps followed by random traffic for instr_mem (DEPTH=4 so the
// pointer wraps often). Expected outputs come from a word-level reference
// model of the memory and fetch pointer kept in this bench.
// ---------------------------------------------------------------------------
module tb_instr_mem;

    localparam int BW     = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [BW-1:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    instr_mem_if #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) bus ();

    instr_mem #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [BW-1:0] ref_mem [DEPTH];
    int            m_pc;
    logic          m_valid;
    logic [BW-1:0] m_instr;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag);
        n_assert++;
        assert (bus.pc === ADDR_W'(m_pc)) else begin
            n_fail++;
            $error("FAIL %s pc: observed %0d expected %0d", tag, bus.pc, m_pc);
        end
        n_assert++;
        assert (bus.instruction === m_instr) else begin
            n_fail++;
            $error("FAIL %s instruction: observed %08h expected %08h", tag, bus.instruction, m_instr);
        end
        n_assert++;
        assert (bus.instr_valid === m_valid) else begin
            n_fail++;
            $error("FAIL %s instr_valid: observed %0b expected %0b", tag, bus.instr_valid, m_valid);
        end
        $display("%0t %-12s rst=%0b next=%0b wr=%0b pc=%0d instr=%08h valid=%0b",
                 $time, tag, rst, bus.next_instr, bus.wr_en, bus.pc, bus.instruction, bus.instr_valid);
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_valid = 1'b0;
        m_instr = NOP;
    endtask

    // Predict the state after the coming edge from the inputs now driven,
    // then run that edge and compare one time unit later.
    task automatic tick(input string tag);
        logic jmp_now;
        int   jmp_tgt;
        jmp_now = 1'b0;
        jmp_tgt = 0;
`ifdef INSTR_MEM_JUMP_EN
        jmp_now = bus.jmp_en;
        jmp_tgt = int'(bus.jmp_addr);
`endif
        if (rst) begin
            model_reset();
        end else begin
            if (jmp_now)
                m_pc = jmp_tgt;
            else if (bus.next_instr && m_valid)
                m_pc = (m_pc + 1) % DEPTH;
            m_instr = ref_mem[m_pc];    // fetched before this edge's write lands
            m_valid = 1'b1;
        end
        if (bus.wr_en)
            ref_mem[int'(bus.wr_addr)] = bus.wr_data;
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst            = 1'b1;
        bus.next_instr = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
`ifdef INSTR_MEM_JUMP_EN
        bus.jmp_en     = 1'b0;
        bus.jmp_addr   = '0;
`endif
        model_reset();
        #1;
        check("reset");

        // Program load while in reset
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'(i);
            bus.wr_data = BW'(32'h11 * (i + 1));
            tick("load");
        end
        bus.wr_en = 1'b0;

        // First fetch
        rst = 1'b0;
        tick("first");

        // Step twice then hold
        bus.next_instr = 1'b1;
        tick("step1");
        tick("step2");
        bus.next_instr = 1'b0;
        tick("hold");

        // Same-address write while holding at pc=2
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd2;
        bus.wr_data = 32'hAA;
        tick("rbw_old");
        bus.wr_en = 1'b0;
        tick("rbw_new");

        // Step through the wrap 3 -> 0 and on to pc=3
        bus.next_instr = 1'b1;
        tick("to3");
        tick("wrap");
        tick("after_wrap");
        tick("to2");
        tick("to3b");
        bus.next_instr = 1'b0;

        // Asynchronous reset mid-cycle at pc=3
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        bus.next_instr = 1'b1;
        tick("in_rst");
        rst = 1'b0;
        bus.next_instr = 1'b0;
        tick("rst_rel");

`ifdef INSTR_MEM_JUMP_EN
        // Jump together with a step: jump wins
        bus.next_instr = 1'b1;
        bus.jmp_en     = 1'b1;
        bus.jmp_addr   = 2'd1;
        tick("jump");
        bus.jmp_en     = 1'b0;
        bus.next_instr = 1'b0;
`endif

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            rst            = ($urandom_range(0, 39) == 0);
            bus.next_instr = $urandom_range(0, 2) != 0;
            bus.wr_en      = ($urandom_range(0, 3) == 0);
            bus.wr_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.wr_data    = $urandom;
`ifdef INSTR_MEM_JUMP_EN
            bus.jmp_en     = ($urandom_range(0, 7) == 0);
            bus.jmp_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
`endif
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_instr_mem
